// File: rtl/ext_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ext_sequencer_pkg
// Brief   : Shared extender selects, instruction classes and FSM states.
// Revision: 1.0
// ============================================================================
package ext_sequencer_pkg;

    localparam logic [1:0] SZE_SEL_IR2110    = 2'b00;
    localparam logic [1:0] SZE_SEL_IR2_MUL70 = 2'b01;
    localparam logic [1:0] SZE_SEL_IR2_70    = 2'b10;
    localparam logic [1:0] SZE_SEL_IR2_230   = 2'b11;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_MUL  = 3'd1,
        CLS_BR   = 3'd2,
        CLS_DPI  = 3'd3,
        CLS_SDT  = 3'd4
    } ins_class_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_MUL    = 2'd2
    } seq_state_t;

    function automatic logic [1:0] sze_sel_of(input ins_class_t cls);
        logic [1:0] sel;
        case (cls)
            CLS_MUL: sel = SZE_SEL_IR2_MUL70;
            CLS_BR:  sel = SZE_SEL_IR2_230;
            CLS_DPI: sel = SZE_SEL_IR2_70;
            default: sel = SZE_SEL_IR2110;
        endcase
        return sel;
    endfunction

    // Only branch offsets are signed; every other immediate is zero-extended.
    function automatic logic sze_ctrl_of(input ins_class_t cls);
        return (cls == CLS_BR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ext_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : ext_sequencer_if
// Brief   : Stage-2 instruction / extender handshake bundle.
// Revision: 1.0
// ============================================================================
interface ext_sequencer_if;
    logic [31:0] ir2;
    logic        ir2_valid;
    logic        ds_ready;
    logic [1:0]  sze_sel;
    logic        sze_ctrl;
    logic        ext_valid;
    logic        ext_last;
    logic [1:0]  mul_byte;
    logic        ir2_stall;

    modport master (
        output ir2, ir2_valid, ds_ready,
        input  sze_sel, sze_ctrl, ext_valid, ext_last, mul_byte, ir2_stall
    );

    modport slave (
        input  ir2, ir2_valid, ds_ready,
        output sze_sel, sze_ctrl, ext_valid, ext_last, mul_byte, ir2_stall
    );
endinterface
`default_nettype wire

// File: rtl/ext_sequencer_classify.sv
`default_nettype none
// ============================================================================
// Module  : ext_classify
// Brief   : Combinational IR2 decode into extender instruction classes.
// Revision: 1.0
// ============================================================================
module ext_classify
    import ext_sequencer_pkg::*;
(
    input  wire logic [31:0] i_ir2,
    output ins_class_t       o_class
);

    logic w_unused_bits;
    assign w_unused_bits = ^{i_ir2[31:28], i_ir2[21:8], i_ir2[3:0]};

    // MUL shares the 000 opcode space with register DP, so it is tested first.
    always_comb begin
        o_class = CLS_NONE;
        if (i_ir2[27:22] == 6'b000000 && i_ir2[7:4] == 4'b1001) begin
            o_class = CLS_MUL;
        end else if (i_ir2[27:25] == 3'b101) begin
            o_class = CLS_BR;
        end else if (i_ir2[27:25] == 3'b001) begin
            o_class = CLS_DPI;
        end else if (i_ir2[27:25] == 3'b010) begin
            o_class = CLS_SDT;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ext_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ext_sequencer
// Brief   : Sequences operand extension (single or multi-byte) for IR2.
// Revision: 1.0
// ============================================================================
module ext_sequencer
    import ext_sequencer_pkg::*;
#(
    parameter int MUL_BYTES = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ext_sequencer_if.slave   bus
);

    localparam logic [1:0] c_LAST_BYTE = 2'(MUL_BYTES - 1);

    seq_state_t  r_state;
    logic [1:0]  r_sze_sel;
    logic        r_sze_ctrl;
    logic        r_ext_valid;
    logic        r_ext_last;
    logic [1:0]  r_mul_byte;
    ins_class_t  w_class;
    logic [1:0]  w_next_byte;
    logic        w_accept;

    ext_classify u_classify (
        .i_ir2   (bus.ir2),
        .o_class (w_class)
    );

    assign w_accept    = bus.ir2_valid && (w_class != CLS_NONE);
    assign w_next_byte = r_mul_byte + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sze_sel   <= SZE_SEL_IR2110;
            r_sze_ctrl  <= 1'b0;
            r_ext_valid <= 1'b0;
            r_ext_last  <= 1'b0;
            r_mul_byte  <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sze_sel   <= sze_sel_of(w_class);
                        r_sze_ctrl  <= sze_ctrl_of(w_class);
                        r_ext_valid <= 1'b1;
                        r_mul_byte  <= 2'd0;
                        if (w_class == CLS_MUL) begin
                            r_state    <= ST_MUL;
                            r_ext_last <= (c_LAST_BYTE == 2'd0);
                        end else begin
                            r_state    <= ST_SINGLE;
                            r_ext_last <= 1'b1;
                        end
                    end
                end
                ST_SINGLE: begin
                    if (bus.ds_ready) begin
                        r_state     <= ST_IDLE;
                        r_ext_valid <= 1'b0;
                        r_ext_last  <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (bus.ds_ready) begin
                        if (r_ext_last) begin
                            r_state     <= ST_IDLE;
                            r_ext_valid <= 1'b0;
                            r_ext_last  <= 1'b0;
                            r_mul_byte  <= 2'd0;
                        end else begin
                            r_mul_byte  <= w_next_byte;
                            r_ext_last  <= (w_next_byte == c_LAST_BYTE);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall releases in the very cycle the final transfer is accepted.
    assign bus.ir2_stall = ((r_state == ST_IDLE) && w_accept) ||
                           ((r_state != ST_IDLE) && !(bus.ds_ready && r_ext_last));

    assign bus.sze_sel   = r_sze_sel;
    assign bus.sze_ctrl  = r_sze_ctrl;
    assign bus.ext_valid = r_ext_valid;
    assign bus.ext_last  = r_ext_last;
    assign bus.mul_byte  = r_mul_byte;

endmodule
`default_nettype wire

// File: tb/tb_ext_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ext_sequencer
// Brief   : Scoreboard bench: directed vectors plus randomized IR2 traffic.
// Revision: 1.0
// ============================================================================
module tb_ext_sequencer;

    localparam int NB = 4;

    typedef struct {
        logic [1:0] sel;
        logic       ctrl;
        logic [1:0] mb;
        logic       last;
    } xfer_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ext_sequencer_if bus ();

    ext_sequencer #(.MUL_BYTES(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    xfer_t      exp_q[$];
    int         checks    = 0;
    int         errors    = 0;
    logic       mon_en    = 1'b0;
    logic [1:0] last_sel  = 2'b00;
    logic       last_ctrl = 1'b0;
    int         pend      = 0;

    // 0 none, 1 mul, 2 branch, 3 data-proc immediate, 4 single data transfer
    function automatic int classify(input logic [31:0] w);
        if (w[27:22] == 6'd0 && w[7:4] == 4'b1001) return 1;
        if (w[27:25] == 3'b101) return 2;
        if (w[27:25] == 3'b001) return 3;
        if (w[27:25] == 3'b010) return 4;
        return 0;
    endfunction

    function automatic logic [1:0] exp_sel(input int cls);
        case (cls)
            1: return 2'b01;
            2: return 2'b11;
            3: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            1: begin w[27:22] = 6'd0; w[7:4] = 4'b1001; end
            2: w[27:25] = 3'b101;
            3: w[27:25] = 3'b001;
            4: w[27:25] = 3'b010;
            default: ;
        endcase
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides stall and what transfers follow.
    task automatic drive_cycle(input logic [31:0] w, input logic v, input logic rdy);
        int    cls;
        int    n;
        logic  es;
        xfer_t nx[$];
        xfer_t x;
        @(negedge clk);
        bus.ir2       = w;
        bus.ir2_valid = v;
        bus.ds_ready  = rdy;
        #1;
        cls = classify(w);
        if (pend == 0) es = v && (cls != 0);
        else           es = !(rdy && pend == 1);
        chk("ir2_stall", {31'd0, bus.ir2_stall}, {31'd0, es});
        if (pend == 0 && v && cls != 0) begin
            n = (cls == 1) ? NB : 1;
            for (int b = 0; b < n; b++) begin
                x.sel  = exp_sel(cls);
                x.ctrl = (cls == 2);
                x.mb   = (cls == 1) ? 2'(b) : 2'd0;
                x.last = (b == n - 1);
                nx.push_back(x);
            end
            pend = n;
        end else if (pend > 0 && rdy) begin
            pend--;
        end
        if (nx.size() != 0) begin
            @(posedge clk);
            #1;
            foreach (nx[i]) exp_q.push_back(nx[i]);
            last_sel  = nx[0].sel;
            last_ctrl = nx[0].ctrl;
        end
    endtask

    // Monitor: compares every presented transfer against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("ext_valid", {31'd0, bus.ext_valid}, {31'd0, exp_q.size() != 0});
                if (bus.ext_valid && exp_q.size() != 0) begin
                    chk("xfer_sel_ctrl_byte_last",
                        {26'd0, bus.sze_sel, bus.sze_ctrl, bus.mul_byte, bus.ext_last},
                        {26'd0, exp_q[0].sel, exp_q[0].ctrl, exp_q[0].mb, exp_q[0].last});
                    if (bus.ds_ready) void'(exp_q.pop_front());
                end else if (!bus.ext_valid) begin
                    chk("idle_hold",
                        {26'd0, bus.sze_sel, bus.sze_ctrl, bus.ext_last, bus.mul_byte},
                        {26'd0, last_sel, last_ctrl, 1'b0, 2'b00});
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.ir2       = 32'd0;
        bus.ir2_valid = 1'b0;
        bus.ds_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state",
            {25'd0, bus.sze_sel, bus.sze_ctrl, bus.ext_valid, bus.ext_last, bus.mul_byte, bus.ir2_stall},
            32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // DPI immediate, consumer always ready
        drive_cycle(32'hE3A000FF, 1'b1, 1'b1);
        drive_cycle(32'hE3A000FF, 1'b1, 1'b1);
        drive_cycle(32'h0, 1'b0, 1'b1);

        // Branch with consumer stalled three cycles
        drive_cycle(32'hEAFFFFFE, 1'b1, 1'b0);
        repeat (3) drive_cycle(32'hEAFFFFFE, 1'b1, 1'b0);
        drive_cycle(32'hEAFFFFFE, 1'b1, 1'b1);
        drive_cycle(32'h0, 1'b0, 1'b1);

        // Multiply, four byte chunks
        drive_cycle(32'hE0000291, 1'b1, 1'b1);
        repeat (NB) drive_cycle(32'hE0000291, 1'b1, 1'b1);
        drive_cycle(32'h0, 1'b0, 1'b1);

        // Register MOV: no extension, no stall
        drive_cycle(32'hE1A00001, 1'b1, 1'b1);
        drive_cycle(32'hE1A00001, 1'b1, 1'b0);

        // Back-to-back SDT then DPI
        drive_cycle(32'hE5910004, 1'b1, 1'b1);
        drive_cycle(32'hE3A000FF, 1'b1, 1'b1);
        drive_cycle(32'hE3A000FF, 1'b1, 1'b1);
        drive_cycle(32'hE3A000FF, 1'b0, 1'b1);
        drive_cycle(32'h0, 1'b0, 1'b1);

        // Reset landing mid-multiply at byte 2
        drive_cycle(32'hE0000291, 1'b1, 1'b1);
        drive_cycle(32'h0, 1'b0, 1'b1);
        drive_cycle(32'h0, 1'b0, 1'b1);
        @(negedge clk);
        mon_en        = 1'b0;
        rst           = 1'b1;
        bus.ir2_valid = 1'b0;
        bus.ds_ready  = 1'b1;
        #1;
        chk("mul_byte_before_reset", {30'd0, bus.mul_byte}, 32'd2);
        @(posedge clk);
        #1;
        chk("mid_mul_reset",
            {25'd0, bus.sze_sel, bus.sze_ctrl, bus.ext_valid, bus.ext_last, bus.mul_byte, bus.ir2_stall},
            32'd0);
        exp_q.delete();
        pend      = 0;
        last_sel  = 2'b00;
        last_ctrl = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive_cycle(gen_instr(), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end

        repeat (NB + 4) drive_cycle(32'h0, 1'b0, 1'b1);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ext_sequencer.md
EXT_SEQUENCER -- requirements
Module: ext_sequencer

Interface
REQ-001 The block SHALL have one parameter: MUL_BYTES, default 4, the number of multiplier byte chunks issued per multiply (legal range 1..4).
REQ-002 CLK  input  1  the single clock; all state SHALL change on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-004 IR2  input  32  instruction word in pipeline stage 2; the same word also feeds the extender operand fields.
REQ-005 IR2_VALID  input  1  IR2 holds a real instruction this cycle.
REQ-006 DS_READY  input  1  the barrel-shifter consumer accepts the current extended operand this cycle.
REQ-007 SZE_SEL  output  2  extender source select, encoded with the shared SZE_SEL_* constants.
REQ-008 SZE_CTRL  output  1  1 selects sign extension; 0 selects zero extension.
REQ-009 EXT_VALID  output  1  the extended operand on the extender output is valid for the consumer.
REQ-010 EXT_LAST  output  1  the current transfer is the final one for this instruction.
REQ-011 MUL_BYTE  output  2  index of the multiplier byte currently routed to IR2_MUL70.
REQ-012 IR2_STALL  output  1  holds IR2 in stage 2 while its operand is still being extended.

Function
REQ-013 Each valid IR2 SHALL be classified, highest priority first:
- MUL: IR2[27:22]=000000 and IR2[7:4]=1001; SZE_SEL=SZE_SEL_IR2_MUL70, SZE_CTRL=0.
- BR: IR2[27:25]=101; SZE_SEL=SZE_SEL_IR2_230, SZE_CTRL=1.
- DPI: IR2[27:25]=001; SZE_SEL=SZE_SEL_IR2_70, SZE_CTRL=0.
- SDT: IR2[27:25]=010; SZE_SEL=SZE_SEL_IR2110, SZE_CTRL=0.
- NONE: all other encodings.
REQ-014 The FSM SHALL have three states: IDLE, SINGLE and MUL.
REQ-015 Transitions out of IDLE: on IR2_VALID with class BR/DPI/SDT, go to SINGLE; with class MUL, go to MUL with MUL_BYTE=0; on NONE or !IR2_VALID, stay in IDLE.
REQ-016 On every IDLE exit, SZE_SEL and SZE_CTRL SHALL be registered from the classification, so they become valid one cycle after acceptance.
REQ-017 SINGLE behaviour:
- EXT_VALID=1 and EXT_LAST=1.
- On DS_READY=1, return to IDLE.
- On DS_READY=0, hold all outputs.
REQ-018 MUL behaviour:
- EXT_VALID=1.
- EXT_LAST=1 only when MUL_BYTE=MUL_BYTES-1.
- Each cycle with DS_READY=1, MUL_BYTE increments; on the cycle where EXT_LAST=1, go to IDLE and clear MUL_BYTE to 0.
REQ-019 If MUL_BYTES=1, a MUL instruction SHALL behave exactly like SINGLE with MUL_BYTE=0.
REQ-020 IR2_STALL SHALL be combinational: (IDLE & IR2_VALID & class≠NONE) | (state≠IDLE & !(DS_READY & EXT_LAST)).
REQ-021 NONE instructions SHALL pass through with no stall, no EXT_VALID and no state change.
REQ-022 In IDLE, EXT_VALID=0, EXT_LAST=0, and SZE_SEL/SZE_CTRL SHALL hold their last registered values.
REQ-023 IR2_VALID SHALL be ignored outside IDLE. A new instruction is accepted only from IDLE, giving a one-cycle bubble between back-to-back extended instructions.
REQ-024 DS_READY SHALL be ignored in IDLE.

Reset
REQ-025 A synchronous RESET SHALL force state=IDLE and SZE_SEL=SZE_SEL_IR2110 (2'b00), and clear SZE_CTRL, EXT_VALID, EXT_LAST and MUL_BYTE to 0.
REQ-026 RESET SHALL take priority over every other input, including mid-SINGLE and mid-MUL. IR2_STALL SHALL be 0 in the cycle after RESET is sampled, unless IR2_VALID with an extending class is present.

Structure
REQ-027 The shared defines/package SHALL contain SZE_SEL_IR2110=00, SZE_SEL_IR2_MUL70=01, SZE_SEL_IR2_70=10 and SZE_SEL_IR2_230=11, plus the FSM state encodings and instruction-class codes.
REQ-028 The instruction classifier SHALL be a separate combinational sub-module, ext_classify (IR2 → class), reused by the decode logic. The FSM, counter and output registers stay in ext_sequencer.

Verification
REQ-029 DPI: IR2=32'hE3A000FF with IR2_VALID, DS_READY=1.
- Cycle 0: IR2_STALL=1.
- Cycle 1: SZE_SEL=10, SZE_CTRL=0, EXT_VALID=1, EXT_LAST=1, IR2_STALL=0.
- Cycle 2: IDLE.
REQ-030 Branch with DS_READY held 0 for 3 cycles: IR2=32'hEAFFFFFE.
- SZE_SEL=11, SZE_CTRL=1, EXT_VALID=1 and IR2_STALL=1 held for 3 cycles.
- Completes in the cycle DS_READY rises.
REQ-031 MUL, MUL_BYTES=4: IR2=32'hE0000291, DS_READY=1.
- MUL_BYTE steps 0,1,2,3 on consecutive cycles.
- EXT_LAST=1 only at 3; IR2_STALL drops in that cycle; returns to IDLE.
REQ-032 RESET asserted while in MUL with MUL_BYTE=2: next cycle IDLE, MUL_BYTE=0, EXT_VALID=0, SZE_SEL=00.
REQ-033 NONE instruction (IR2=32'hE1A00001, register MOV): no stall, EXT_VALID stays 0, state stays IDLE.
REQ-034 Back-to-back SDT (IR2=32'hE5910004) then DPI: the DPI is accepted only from IDLE after the SDT completes; SDT outputs SZE_SEL=00, SZE_CTRL=0.
